// File: rtl/mem_arb_pkg.sv
// mem_arb shared types: FSM state enum, last-grant encodings, counter width.
// Imported by every mem_arb file.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_HOST = 2'd2
  } state_t;

  localparam logic LG_CPU  = 1'b0;
  localparam logic LG_HOST = 1'b1;

  localparam int CNT_W = 16;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb requester port: req/we/addr/wdata toward the arbiter, ack/rdata back.
// master = requester side, slave = arbiter side.
interface mem_arb_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick: combinational 2-way round-robin selector.
// req[0]=cpu, req[1]=host; last_gnt: 0=cpu, 1=host; gnt one-hot or zero.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // On conflict the requester that did not win last time goes next.
  assign gnt[0] = req[0] & (~req[1] | (last_gnt == LG_HOST));
  assign gnt[1] = req[1] & (~req[0] | (last_gnt == LG_CPU));

endmodule

// File: rtl/mem_arb.sv
// mem_arb: CPU/host arbiter for one shared data memory port.
// Ports: clk, rst_f (sync, active-low), cpu/host (mem_arb_if.slave),
// dm_addr/dm_wdata/dm_we out, dm_rdata in, wait_cnt out.
// `define MEM_ARB_WAITCNT_EN enables the saturating wait counter.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst_f,
  mem_arb_if.slave         cpu,
  mem_arb_if.slave         host,
  output logic [AW-1:0]    dm_addr,
  output logic [DW-1:0]    dm_wdata,
  output logic             dm_we,
  input  logic [DW-1:0]    dm_rdata,
  output logic [CNT_W-1:0] wait_cnt
);

  state_t     state;
  logic       last_gnt;
  logic [1:0] req;
  logic [1:0] gnt;

  assign req = {host.req, cpu.req};

  mem_arb_rr_pick u_pick (
    .req      (req),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state    <= IDLE;
      last_gnt <= LG_HOST;
    end else begin
      unique case (1'b1)
        gnt[0]: begin
          state    <= GNT_CPU;
          last_gnt <= LG_CPU;
        end
        gnt[1]: begin
          state    <= GNT_HOST;
          last_gnt <= LG_HOST;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory side follows the granted requester but only while it
  // still asserts req, so a withdrawn request never writes.
  always_comb begin
    dm_addr    = '0;
    dm_wdata   = '0;
    dm_we      = 1'b0;
    cpu.ack    = 1'b0;
    cpu.rdata  = '0;
    host.ack   = 1'b0;
    host.rdata = '0;
    unique case (state)
      GNT_CPU: begin
        if (cpu.req) begin
          dm_addr  = cpu.addr;
          dm_wdata = cpu.wdata;
          dm_we    = cpu.we;
        end
        cpu.ack   = cpu.req;
        cpu.rdata = dm_rdata;
      end
      GNT_HOST: begin
        if (host.req) begin
          dm_addr  = host.addr;
          dm_wdata = host.wdata;
          dm_we    = host.we;
        end
        host.ack   = host.req;
        host.rdata = dm_rdata;
      end
      default: ;
    endcase
  end

`ifdef MEM_ARB_WAITCNT_EN
  logic [1:0]       n_wait;
  logic [CNT_W:0]   wait_sum;
  logic [CNT_W-1:0] wait_q;

  // Each stalled requester adds one per cycle, so a cycle with
  // both waiting adds two.
  always_comb begin
    n_wait   = {1'b0, cpu.req & ~cpu.ack}
             + {1'b0, host.req & ~host.ack};
    wait_sum = {1'b0, wait_q} + {{(CNT_W-1){1'b0}}, n_wait};
  end

  always_ff @(posedge clk) begin
    if (!rst_f)
      wait_q <= '0;
    else if (wait_sum[CNT_W])
      wait_q <= '1;
    else
      wait_q <= wait_sum[CNT_W-1:0];
  end

  assign wait_cnt = wait_q;
`else
  assign wait_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed vector table plus hand sequences for mem_arb.
// Checks grants, muxing, gating, reset, round-robin and wait_cnt.
module tb_mem_arb;

  logic        clk;
  logic        rst_f;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [31:0] dm_rdata;
  logic [15:0] wait_cnt;

  int checks;
  int failures;

  mem_arb_if #(.AW(16), .DW(32)) cpu_if ();
  mem_arb_if #(.AW(16), .DW(32)) host_if ();

  mem_arb #(.AW(16), .DW(32)) dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .cpu      (cpu_if),
    .host     (host_if),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_we    (dm_we),
    .dm_rdata (dm_rdata),
    .wait_cnt (wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        creq;
    logic        cwe;
    logic [15:0] caddr;
    logic [31:0] cwd;
    logic        hreq;
    logic        hwe;
    logic [15:0] haddr;
    logic [31:0] hwd;
    logic [31:0] rd;
    logic        cack;
    logic        hack;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [31:0] crd;
    logic [31:0] hrd;
    logic [15:0] wc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] wexp(input logic [15:0] w);
`ifdef MEM_ARB_WAITCNT_EN
    return w;
`else
    return 16'h0 & w;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    rst_f         = v.rst;
    cpu_if.req    = v.creq;
    cpu_if.we     = v.cwe;
    cpu_if.addr   = v.caddr;
    cpu_if.wdata  = v.cwd;
    host_if.req   = v.hreq;
    host_if.we    = v.hwe;
    host_if.addr  = v.haddr;
    host_if.wdata = v.hwd;
    dm_rdata      = v.rd;
  endtask

  task automatic idle_in();
    cpu_if.req    = 1'b0;
    cpu_if.we     = 1'b0;
    cpu_if.addr   = '0;
    cpu_if.wdata  = '0;
    host_if.req   = 1'b0;
    host_if.we    = 1'b0;
    host_if.addr  = '0;
    host_if.wdata = '0;
    dm_rdata      = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_f = 1'b0;
    tick();
    rst_f = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_f    = 1'b0;
    idle_in();

    //        rst creq cwe caddr  cwd           hreq hwe haddr  hwd
    //        rd            cack hack we addr   wd            crd
    //        hrd           wc
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0,
                32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0,
                32'h0, 32'h0, 16'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 16'h8, 32'hA5A5A5A5, 1'b0, 1'b0,
                16'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 16'h8,
                32'hA5A5A5A5, 32'h0, 32'h0, 16'd1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'h9,
                32'h0, 32'h1234, 1'b0, 1'b1, 1'b0, 16'h9, 32'h0,
                32'h0, 32'h1234, 16'd2};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h5, 32'h5, 1'b0, 1'b0, 16'h0,
                32'h0, 32'hDEAD, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0,
                32'h0, 32'h0, 16'd2};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h3, 32'h11, 1'b1, 1'b1, 16'h4,
                32'h22, 32'h77, 1'b1, 1'b0, 1'b1, 16'h3, 32'h11,
                32'h77, 32'h0, 16'd4};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 16'h3, 32'h11, 1'b1, 1'b1, 16'h4,
                32'h22, 32'h77, 1'b0, 1'b1, 1'b1, 16'h4, 32'h22,
                32'h0, 32'h77, 16'd5};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 16'h3, 32'h11, 1'b1, 1'b1, 16'h4,
                32'h22, 32'h77, 1'b1, 1'b0, 1'b1, 16'h3, 32'h11,
                32'h77, 32'h0, 16'd6};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 16'h3, 32'h11, 1'b1, 1'b1, 16'h1F,
                32'hCAFE, 32'h0, 1'b0, 1'b1, 1'b1, 16'h1F, 32'hCAFE,
                32'h0, 32'h0, 16'd7};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 16'h3, 32'h11, 1'b1, 1'b1, 16'h1F,
                32'hCAFE, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0,
                32'h0, 32'h0, 16'd0};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0,
                32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0,
                32'h0, 32'h0, 16'd0};

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i]);
      tick();
      chk($sformatf("v%0d cpu_ack", i), 32'(cpu_if.ack), 32'(vecs[i].cack));
      chk($sformatf("v%0d host_ack", i), 32'(host_if.ack), 32'(vecs[i].hack));
      chk($sformatf("v%0d dm_we", i), 32'(dm_we), 32'(vecs[i].we));
      chk($sformatf("v%0d dm_addr", i), 32'(dm_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d dm_wdata", i), dm_wdata, vecs[i].wd);
      chk($sformatf("v%0d cpu_rdata", i), cpu_if.rdata, vecs[i].crd);
      chk($sformatf("v%0d host_rdata", i), host_if.rdata, vecs[i].hrd);
      chk($sformatf("v%0d wait_cnt", i), 32'(wait_cnt),
          32'(wexp(vecs[i].wc)));
    end

    // Both held from IDLE: CPU, HOST, CPU, HOST.
    do_reset();
    cpu_if.req  = 1'b1;
    host_if.req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("rr%0d cpu_ack", g), 32'(cpu_if.ack),
          32'((g % 2) == 0));
      chk($sformatf("rr%0d host_ack", g), 32'(host_if.ack),
          32'((g % 2) == 1));
    end
    chk("rr wait_cnt", 32'(wait_cnt), 32'(wexp(16'd5)));

    // Withdraw mid-grant: no write, no ack, then IDLE.
    do_reset();
    cpu_if.req   = 1'b1;
    cpu_if.we    = 1'b1;
    cpu_if.addr  = 16'h40;
    cpu_if.wdata = 32'h55;
    tick();
    chk("wd granted ack", 32'(cpu_if.ack), 32'd1);
    chk("wd granted we", 32'(dm_we), 32'd1);
    #2;
    cpu_if.req = 1'b0;
    #1;
    chk("wd drop ack", 32'(cpu_if.ack), 32'd0);
    chk("wd drop we", 32'(dm_we), 32'd0);
    chk("wd drop addr", 32'(dm_addr), 32'd0);
    tick();
    cpu_if.req = 1'b1;
    #1;
    chk("wd idle ack", 32'(cpu_if.ack), 32'd0);
    chk("wd idle we", 32'(dm_we), 32'd0);

    // Reset during a host store grant.
    do_reset();
    host_if.req   = 1'b1;
    host_if.we    = 1'b1;
    host_if.addr  = 16'h7;
    host_if.wdata = 32'h99;
    tick();
    chk("mr granted ack", 32'(host_if.ack), 32'd1);
    chk("mr granted we", 32'(dm_we), 32'd1);
    rst_f = 1'b0;
    tick();
    chk("mr reset ack", 32'(host_if.ack), 32'd0);
    chk("mr reset we", 32'(dm_we), 32'd0);
    chk("mr reset wait", 32'(wait_cnt), 32'd0);
    rst_f = 1'b1;

`ifdef MEM_ARB_WAITCNT_EN
    // Saturation at 16'hFFFF under a held conflict.
    do_reset();
    cpu_if.req  = 1'b1;
    host_if.req = 1'b1;
    force dut.wait_q = 16'hFFFE;
    #1;
    release dut.wait_q;
    for (int s = 0; s < 4; s++) begin
      tick();
      chk($sformatf("sat%0d wait_cnt", s), 32'(wait_cnt), 32'hFFFF);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
